// File: rtl/hazard_ctrl_pkg.sv
// Types and constants shared by hazard_ctrl and its comparator sub-module.
package hazard_ctrl_pkg;
    localparam int ADDR_W      = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    localparam int EXT_LAT_DEF = 3;

    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t dst;
        logic      we;
        logic      load;
    } ex_rec_t;

    typedef struct packed {
        reg_addr_t dst;
        logic      we;
    } dm_rec_t;
endpackage

// File: rtl/hazard_cmp.sv
// One source-vs-stage comparison: a live write to the same nonzero register.
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic              we,
    output logic              match
);
    assign match = we && (src != REG_ZERO) && (src == dst);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: bypass selects, load-use and ext-unit stalls.
// Define HAZARD_EXT_EN to build the multi-cycle ext-unit tracking.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int EXT_LAT = EXT_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] src0_addr,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              we_ID,
    input  logic              load_ID,
    input  logic              ext_ID,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              stall_IF_ID,
    output logic              stall_ID_EX,
    output logic              stall_EX_DM,
    output logic              bubble_ID_EX,
    output logic              byp0_EX,
    output logic              byp0_ext_EX,
    output logic              byp0_DM,
    output logic              byp1_EX,
    output logic              byp1_ext_EX,
    output logic              byp1_DM,
    output logic              ext_wb
);

    ex_rec_t ex_q;
    dm_rec_t dm_q;

    logic [NUM_SRC-1:0][ADDR_W-1:0] src;
    logic [NUM_SRC-1:0] hit_ex, hit_dm, hit_ext;
    logic [NUM_SRC-1:0] byp_ex_q, byp_ext_q, byp_dm_q;
    logic load_use, ext_raw, ext_struct, ext_wb_c, ex_we_in;
    logic hazard, bubble;

    assign src = {src1_addr, src0_addr};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_cmp u_cmp_ex (
            .src  (src[s]),
            .dst  (ex_q.dst),
            .we   (ex_q.we),
            .match(hit_ex[s])
        );
        hazard_cmp u_cmp_dm (
            .src  (src[s]),
            .dst  (dm_q.dst),
            .we   (dm_q.we),
            .match(hit_dm[s])
        );
    end

`ifdef HAZARD_EXT_EN
    logic [CNT_W-1:0]   ext_cnt;
    reg_addr_t          ext_dst;
    logic               ext_pend;
    logic               ext_issue;
    logic [NUM_SRC-1:0] hit_ext_any;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_ext
        hazard_cmp u_cmp_ext (
            .src  (src[s]),
            .dst  (ext_dst),
            .we   (ext_pend),
            .match(hit_ext_any[s])
        );
    end

    // Result lands next cycle when cnt==1, so it can be forwarded; earlier is a stall.
    assign hit_ext    = (ext_cnt == 4'd1) ? hit_ext_any : '0;
    assign ext_raw    = (ext_cnt >= 4'd2) && (|hit_ext_any);
    assign ext_struct = ext_ID && ext_pend;
    assign ext_wb_c   = ext_pend && (ext_cnt == 4'd0);
    assign ext_issue  = ext_ID && !bubble && !mem_stall;
    // The ext result is written by ext_wb, not by the normal EX/DM path.
    assign ex_we_in   = we_ID && !ext_ID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_cnt  <= '0;
            ext_dst  <= '0;
            ext_pend <= 1'b0;
        end else if (ext_issue) begin
            ext_cnt  <= CNT_W'(EXT_LAT);
            ext_dst  <= dst_addr;
            ext_pend <= 1'b1;
        end else begin
            if (!mem_stall && ext_cnt != '0)
                ext_cnt <= ext_cnt - 4'd1;
            if (ext_wb_c)
                ext_pend <= 1'b0;
        end
    end
`else
    logic unused_ext;

    assign hit_ext    = '0;
    assign ext_raw    = 1'b0;
    assign ext_struct = 1'b0;
    assign ext_wb_c   = 1'b0;
    assign ex_we_in   = we_ID;
    assign unused_ext = ext_ID ^ (^(CNT_W'(EXT_LAT)));
`endif

    assign load_use = ex_q.load && (|hit_ex);
    assign hazard   = load_use || ext_raw || ext_struct;
    assign bubble   = !mem_stall && (flush || hazard);

    // Stage records and bypass selects all freeze together under mem_stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            dm_q      <= '0;
            byp_ex_q  <= '0;
            byp_ext_q <= '0;
            byp_dm_q  <= '0;
        end else if (!mem_stall) begin
            dm_q <= '{dst: ex_q.dst, we: ex_q.we};
            if (bubble)
                ex_q <= '0;
            else
                ex_q <= '{dst: dst_addr, we: ex_we_in, load: load_ID};
            byp_ex_q  <= hit_ex;
            byp_ext_q <= hit_ext & ~hit_ex;
            byp_dm_q  <= hit_dm & ~hit_ex & ~hit_ext;
        end
    end

    assign stall_IF_ID  = rst_n && (mem_stall || (hazard && !flush));
    assign stall_ID_EX  = rst_n && mem_stall;
    assign stall_EX_DM  = rst_n && mem_stall;
    assign bubble_ID_EX = rst_n && bubble;
    assign ext_wb       = rst_n && ext_wb_c;

    assign byp0_EX     = byp_ex_q[0];
    assign byp0_ext_EX = byp_ext_q[0];
    assign byp0_DM     = byp_dm_q[0];
    assign byp1_EX     = byp_ex_q[1];
    assign byp1_ext_EX = byp_ext_q[1];
    assign byp1_DM     = byp_dm_q[1];

endmodule
